// File: rtl/huffman_pkg.sv
// Shared Huffman code table and helpers, common to the encoder and decoder.
// Codes are stored right-aligned, so a prefix of length L occupies the low L bits.
package huffman_pkg;

    localparam int MAX_LEN  = 10;
    localparam int LEN_W    = 4;
    localparam int SYM_W    = 7;
    localparam int NUM_SYMS = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic             hit;
        logic [SYM_W-1:0] ascii;
    } match_t;

    // Prefix-free: no code is a leading substring of another.
    localparam logic [MAX_LEN-1:0] CODE_TABLE [NUM_SYMS] = '{
        10'b0000000111, 10'b0000000010, 10'b0000001101, 10'b1100110101
    };
    localparam logic [LEN_W-1:0] LEN_TABLE [NUM_SYMS] = '{
        4'd3, 4'd3, 4'd4, 4'd10
    };
    localparam logic [SYM_W-1:0] ASCII_TABLE [NUM_SYMS] = '{
        7'h20, 7'h65, 7'h74, 7'h7A
    };

    function automatic match_t lookup_code(input logic [MAX_LEN-1:0] prefix,
                                           input logic [LEN_W-1:0]   len);
        match_t m;
        m = '0;
        for (int i = 0; i < NUM_SYMS; i++) begin
            if (len == LEN_TABLE[i] && prefix == CODE_TABLE[i]) begin
                m.hit   = 1'b1;
                m.ascii = ASCII_TABLE[i];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/huffman_decoder_match.sv
// Combinational exact-length match of an accumulated prefix against the code table.
module huffman_match #(
    parameter int MAX_LEN = 10,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] prefix,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic [6:0]         ascii
);
    import huffman_pkg::NUM_SYMS;
    import huffman_pkg::CODE_TABLE;
    import huffman_pkg::LEN_TABLE;
    import huffman_pkg::ASCII_TABLE;

    logic [NUM_SYMS-1:0] hit_vec;
    logic [6:0]          ascii_vec [NUM_SYMS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SYMS; gi++) begin : g_entry
            assign hit_vec[gi]   = (len == LEN_W'(LEN_TABLE[gi])) &&
                                   (prefix == MAX_LEN'(CODE_TABLE[gi]));
            assign ascii_vec[gi] = hit_vec[gi] ? ASCII_TABLE[gi] : 7'd0;
        end
    endgenerate

    // Table is prefix-free, so at most one entry hits and OR-ing is safe.
    always_comb begin
        ascii = 7'd0;
        for (int i = 0; i < NUM_SYMS; i++) begin
            ascii = ascii | ascii_vec[i];
        end
        hit = |hit_vec;
    end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: shifts code bits MSB-first, emits a 7-bit ASCII
// symbol on a table hit, or pulses err after MAX_LEN bits without a hit.
module huffman_decoder #(
    parameter int MAX_LEN = 10,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic [6:0]       ascii_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [LEN_W-1:0] code_len,
    output logic             err
);
    import huffman_pkg::state_t;
    import huffman_pkg::ACCUM;
    import huffman_pkg::HOLD;

    localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MAX_LEN);

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] shreg_reg, shreg_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [6:0]         ascii_reg, ascii_next;
    logic [LEN_W-1:0]   code_len_reg, code_len_next;
    logic               err_reg, err_next;

    logic [MAX_LEN-1:0] prefix;
    logic [LEN_W-1:0]   len_inc;
    logic               hit;
    logic [6:0]         hit_ascii;

    assign prefix  = {shreg_reg[MAX_LEN-2:0], bit_in};
    assign len_inc = len_reg + LEN_W'(1);

    huffman_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .prefix (prefix),
        .len    (len_inc),
        .hit    (hit),
        .ascii  (hit_ascii)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ACCUM;
            shreg_reg    <= '0;
            len_reg      <= '0;
            ascii_reg    <= '0;
            code_len_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            len_reg      <= len_next;
            ascii_reg    <= ascii_next;
            code_len_reg <= code_len_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        len_next      = len_reg;
        ascii_next    = ascii_reg;
        code_len_next = code_len_reg;
        err_next      = 1'b0;
        unique case (state_reg)
            ACCUM: begin
                if (flush) begin
                    shreg_next = '0;
                    len_next   = '0;
                end else if (bit_valid) begin
                    shreg_next = prefix;
                    len_next   = len_inc;
                    if (hit) begin
                        ascii_next    = hit_ascii;
                        code_len_next = len_inc;
                        shreg_next    = '0;
                        len_next      = '0;
                        state_next    = HOLD;
                    end else if (len_inc == LAST_LEN) begin
                        err_next   = 1'b1;
                        shreg_next = '0;
                        len_next   = '0;
                    end
                end
            end
            HOLD: begin
                if (sym_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign bit_ready = (state_reg == ACCUM);
    assign sym_valid = (state_reg == HOLD);
    assign ascii_out = ascii_reg;
    assign code_len  = code_len_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench: directed cases plus random code streams checked
// against a list-lookup model of the code table.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       flush = 1'b0;
    logic [6:0] ascii_out;
    logic       sym_valid;
    logic       sym_ready = 1'b1;
    logic [3:0] code_len;
    logic       err;

    int vectors = 0;
    int errors  = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        bit is_err;
        int ascii;
        int len;
    } exp_t;
    exp_t exp_q[$];

    // Reference table, written from the code list: ' ', 'e', 't', 'z'.
    int t_code  [4] = '{'b111, 'b010, 'b1101, 'b1100110101};
    int t_len   [4] = '{3, 3, 4, 10};
    int t_ascii [4] = '{'h20, 'h65, 'h74, 'h7A};
    int cur_val = 0;
    int cur_len = 0;

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .flush     (flush),
        .ascii_out (ascii_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .code_len  (code_len),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_bit(input logic b);
        exp_t e;
        bit   matched = 1'b0;
        cur_val = cur_val * 2 + int'(b);
        cur_len++;
        for (int i = 0; i < 4; i++) begin
            if (cur_len == t_len[i] && cur_val == t_code[i]) begin
                e.is_err = 1'b0; e.ascii = t_ascii[i]; e.len = t_len[i];
                exp_q.push_back(e);
                matched = 1'b1;
            end
        end
        if (!matched && cur_len == 10) begin
            e.is_err = 1'b1; e.ascii = 0; e.len = 0;
            exp_q.push_back(e);
            matched = 1'b1;
        end
        if (matched) begin
            cur_val = 0;
            cur_len = 0;
        end
    endtask

    // Returns at posedge+1 of the edge that accepted the bit.
    task automatic send_bit(input logic b);
        int n = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        while (!bit_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("bit_accept_timeout", 32'(bit_ready), 32'd1);
        if (bit_ready) model_bit(b);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input int code, input int len);
        for (int i = len - 1; i >= 0; i--) send_bit(code[i]);
    endtask

    // A raised bit_valid during flush must be ignored.
    task automatic do_flush();
        flush     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        bit_valid = 1'b0;
        cur_val   = 0;
        cur_len   = 0;
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            sym_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (err && sym_valid) check("err_and_sym_valid", 32'(err & sym_valid), 32'd0);
            if (err) begin
                $display("err pulse");
                check("err_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("err_kind", 32'(exp_q.pop_front().is_err), 32'd1);
            end
            if (sym_valid && sym_ready) begin
                $display("symbol 0x%02h len %0d", ascii_out, code_len);
                check("sym_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sym_kind", 32'(e.is_err), 32'd0);
                    check("sym_ascii", 32'(ascii_out), 32'(e.ascii));
                    check("sym_len", 32'(code_len), 32'(e.len));
                end
            end
        end
    end

    initial begin
        #12;
        check("rst_bit_ready", 32'(bit_ready), 32'd1);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ascii", 32'(ascii_out), 32'd0);
        check("rst_code_len", 32'(code_len), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_code('b111, 3);
        check("lat_sym_valid", 32'(sym_valid), 32'd1);
        check("lat_bit_ready", 32'(bit_ready), 32'd0);
        check("lat_ascii", 32'(ascii_out), 32'h20);
        check("lat_len", 32'(code_len), 32'd3);

        send_code('b010, 3);
        send_code('b1101, 4);
        send_code('b1100110101, 10);

        for (int i = 0; i < 10; i++) send_bit(1'b0);
        check("err_pulse", 32'(err), 32'd1);
        check("err_no_sym", 32'(sym_valid), 32'd0);
        @(posedge clk);
        #1;
        check("err_one_cycle", 32'(err), 32'd0);

        sym_ready = 1'b0;
        send_code('b111, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(sym_valid), 32'd1);
            check("hold_ready", 32'(bit_ready), 32'd0);
            check("hold_ascii", 32'(ascii_out), 32'h20);
            check("hold_len", 32'(code_len), 32'd3);
        end
        do_flush();
        check("hold_flush_kept", 32'(sym_valid), 32'd1);
        sym_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(sym_valid), 32'd0);
        check("release_ready", 32'(bit_ready), 32'd1);

        send_bit(1'b1);
        send_bit(1'b1);
        do_flush();
        send_code('b010, 3);

        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bit_ready", 32'(bit_ready), 32'd1);
        check("async_sym_valid", 32'(sym_valid), 32'd0);
        check("async_ascii", 32'(ascii_out), 32'd0);
        check("async_len", 32'(code_len), 32'd0);
        check("async_err", 32'(err), 32'd0);
        cur_val = 0;
        cur_len = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_code('b111, 3);
        check("post_rst_ascii", 32'(ascii_out), 32'h20);

        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                send_code(t_code[r], t_len[r]);
            end else if (r < 8) begin
                int n;
                n = int'($urandom_range(1, 12));
                for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)));
            end else if (r == 8) begin
                do_flush();
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        sym_ready = 1'b1;

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
